// File: rtl/dram_access_ctrl.sv
// Splits one CPU byte/half/word load or store into single-byte DRAM beats, little-endian,
// with alignment checking, load extension and a one-cycle response pulse.
module dram_access_ctrl #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WORD_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [WORD_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  output logic                  mem_we,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                state_q, state_d;
  logic [1:0]            beat_q, beat_d;
  logic [1:0]            size_q, size_d;
  logic                  we_q, we_d;
  logic                  sgn_q, sgn_d;
  logic                  err_q, err_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  mem_we_q, mem_we_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [WORD_WIDTH-1:0] resp_rdata_q, resp_rdata_d;

  logic                  req_bad;
  logic [1:0]            last_beat;
  logic [1:0]            next_beat;
  logic [WORD_WIDTH-1:0] load_ext;

  always_comb begin
    req_bad = (req_size == 2'b11) ||
              ((req_size == 2'b01) && req_addr[0]) ||
              ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
  end

  always_comb begin
    case (size_q)
      2'b00:   last_beat = 2'd0;
      2'b01:   last_beat = 2'd1;
      default: last_beat = 2'd3;
    endcase
  end

  assign next_beat = beat_q + 2'd1;

  always_comb begin
    case (size_q)
      2'b00:   load_ext = {{(WORD_WIDTH-8){sgn_q & data_q[7]}}, data_q[7:0]};
      2'b01:   load_ext = {{(WORD_WIDTH-16){sgn_q & data_q[15]}}, data_q[15:0]};
      default: load_ext = data_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    size_d       = size_q;
    we_d         = we_q;
    sgn_d        = sgn_q;
    err_d        = err_q;
    base_d       = base_q;
    data_d       = data_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_d     = mem_we_q;
    resp_valid_d = 1'b0;
    resp_err_d   = 1'b0;
    resp_rdata_d = '0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d = req_addr;
          we_d   = req_we;
          size_d = req_size;
          sgn_d  = req_signed;
          data_d = req_wdata;
          beat_d = 2'd0;
          if (req_bad) begin
            err_d    = 1'b1;
            mem_we_d = 1'b0;
            state_d  = DONE;
          end else begin
            err_d       = 1'b0;
            mem_addr_d  = req_addr;
            mem_we_d    = req_we;
            mem_wdata_d = req_wdata[7:0];
            state_d     = XFER;
          end
        end
      end
      XFER: begin
        // Loads capture the byte presented during this beat as the beat closes.
        if (!we_q) begin
          data_d[{beat_q, 3'b000} +: 8] = mem_rdata;
        end
        if (beat_q == last_beat) begin
          mem_we_d = 1'b0;
          state_d  = DONE;
        end else begin
          beat_d      = next_beat;
          mem_addr_d  = base_q + ADDR_WIDTH'(next_beat);
          mem_wdata_d = data_q[{next_beat, 3'b000} +: 8];
        end
      end
      DONE: begin
        resp_valid_d = 1'b1;
        resp_err_d   = err_q;
        resp_rdata_d = (err_q || we_q) ? '0 : load_ext;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      size_q       <= '0;
      we_q         <= 1'b0;
      sgn_q        <= 1'b0;
      err_q        <= 1'b0;
      base_q       <= '0;
      data_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_we_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      size_q       <= size_d;
      we_q         <= we_d;
      sgn_q        <= sgn_d;
      err_q        <= err_d;
      base_q       <= base_d;
      data_q       <= data_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_we_q     <= mem_we_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign req_ready  = (state_q == IDLE);
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_we     = mem_we_q;

endmodule

// File: tb/tb_dram_access_ctrl.sv
// Directed bench for dram_access_ctrl with a byte DRAM model and a response scoreboard.
module tb_dram_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic [7:0]  mem_rdata;

  always #5 clk = ~clk;

  dram_access_ctrl #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  logic [7:0] dram [0:65535];
  assign mem_rdata = dram[mem_addr[15:0]];
  always @(negedge clk) if (mem_we) dram[mem_addr[15:0]] <= mem_wdata;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   acc_q[$];
  int   ncyc = 0;
  int   we_cnt = 0;
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic [7:0] init_val(input int a);
    return 8'(a ^ 32'hA5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Scoreboard: accepts are timestamped at the negedge before the accept edge.
  always @(negedge clk) begin
    exp_t e;
    int   a;
    ncyc++;
    if (mem_we) we_cnt++;
    if (!rst_n) begin
      acc_q.delete();
    end else begin
      if (resp_valid) begin
        if (exp_q.size() == 0 || acc_q.size() == 0) begin
          compared++;
          mismatched++;
          $error("FAIL unexpected_resp: observed resp_valid=1 expected no response");
        end else begin
          e = exp_q.pop_front();
          a = acc_q.pop_front();
          check("resp_rdata", resp_rdata, e.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, e.err});
          check("latency", 32'(ncyc - a - 1), 32'(e.lat));
        end
      end
      if (req_valid && req_ready) acc_q.push_back(ncyc);
    end
  end

  task automatic send(input bit we, input logic [1:0] size, input bit sgn,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input bit expect_resp, input logic [31:0] erd,
                      input bit eerr, input int elat);
    exp_t e;
    int   n;
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    if (expect_resp) begin
      e.rdata = erd; e.err = eerr; e.lat = elat;
      exp_q.push_back(e);
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 40);
    if (!req_ready) begin
      compared++;
      mismatched++;
      $error("FAIL accept_timeout: observed req_ready=0 expected 1");
    end
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_we     = 1'(($urandom));
    req_size   = 2'($urandom);
    req_signed = 1'($urandom);
    req_addr   = $urandom;
    req_wdata  = $urandom;
  endtask

  task automatic wait_resp();
    int n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      compared++;
      mismatched++;
      $error("FAIL resp_timeout: observed %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) dram[i] = init_val(i);

    #2;
    check("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", {24'd0, mem_wdata}, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Word store then word load.
    we_cnt = 0;
    send(1, 2'b10, 0, 32'h1000, 32'hDEADBEEF, 1, 32'h0, 0, 5);
    wait_resp();
    check("st_we_cycles", 32'(we_cnt), 32'd4);
    check("st_bytes", {dram[16'h1003], dram[16'h1002], dram[16'h1001], dram[16'h1000]}, 32'hDEADBEEF);
    we_cnt = 0;
    send(0, 2'b10, 0, 32'h1000, 32'h0, 1, 32'hDEADBEEF, 0, 5);
    wait_resp();
    check("ld_we_cycles", 32'(we_cnt), 32'd0);

    // Sub-word loads with extension.
    send(0, 2'b00, 1, 32'h1003, 32'h0, 1, 32'hFFFFFFDE, 0, 2);
    wait_resp();
    send(0, 2'b00, 0, 32'h1003, 32'h0, 1, 32'h000000DE, 0, 2);
    wait_resp();
    send(0, 2'b01, 1, 32'h1002, 32'h0, 1, 32'hFFFFDEAD, 0, 3);
    wait_resp();
    send(0, 2'b01, 0, 32'h1000, 32'h0, 1, 32'h0000BEEF, 0, 3);
    wait_resp();

    // Error paths: no DRAM access, memory unchanged.
    we_cnt = 0;
    send(0, 2'b10, 0, 32'h1001, 32'h0, 1, 32'h0, 1, 1);
    wait_resp();
    send(0, 2'b11, 1, 32'h1000, 32'h0, 1, 32'h0, 1, 1);
    wait_resp();
    send(1, 2'b01, 0, 32'h1001, 32'h12345678, 1, 32'h0, 1, 1);
    wait_resp();
    send(1, 2'b10, 0, 32'h1002, 32'h12345678, 1, 32'h0, 1, 1);
    wait_resp();
    check("err_we_cycles", 32'(we_cnt), 32'd0);
    check("err_mem_intact", {dram[16'h1003], dram[16'h1002], dram[16'h1001], dram[16'h1000]}, 32'hDEADBEEF);

    // Second request held during XFER of the first; no interleaving.
    we_cnt = 0;
    send(1, 2'b10, 0, 32'h3000, 32'hCAFEF00D, 1, 32'h0, 0, 5);
    check("busy_req_ready", {31'd0, req_ready}, 32'd0);
    send(0, 2'b10, 0, 32'h3000, 32'h0, 1, 32'hCAFEF00D, 0, 5);
    wait_resp();
    check("b2b_we_cycles", 32'(we_cnt), 32'd4);
    send(1, 2'b00, 0, 32'h3005, 32'hFFFFFF77, 1, 32'h0, 0, 2);
    send(0, 2'b00, 1, 32'h3005, 32'h0, 1, 32'h00000077, 0, 2);
    send(1, 2'b01, 0, 32'h3006, 32'h00008001, 1, 32'h0, 0, 3);
    send(0, 2'b01, 1, 32'h3006, 32'h0, 1, 32'hFFFF8001, 0, 3);
    wait_resp();
    check("b2b_bytes", {dram[16'h3007], dram[16'h3006], dram[16'h3005]}, 32'h00800177);

    // Reset in the middle of a word store.
    send(1, 2'b10, 0, 32'h2000, 32'h11223344, 0, 32'h0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("abort_mem_we", {31'd0, mem_we}, 32'd0);
    check("abort_req_ready", {31'd0, req_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_b0", {24'd0, dram[16'h2000]}, 32'h44);
    check("abort_b1", {24'd0, dram[16'h2001]}, 32'h33);
    check("abort_b2", {24'd0, dram[16'h2002]}, {24'd0, init_val(32'h2002)});
    check("abort_b3", {24'd0, dram[16'h2003]}, {24'd0, init_val(32'h2003)});
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    send(0, 2'b10, 0, 32'h1000, 32'h0, 1, 32'hDEADBEEF, 0, 5);
    wait_resp();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
